uart_tx_arbiter: RTL and testbench



---
 rtl/uart_ctl_pkg.sv | 46 ++++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctl_pkg
// Description : Shared types, constants and the round-robin pick helper for
//               the UART transmitter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ctl_pkg;

    localparam int BYTE_W  = 8;
    // Widest requester vector the pick helper supports.
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    // One-hot of the first set bit of vec at or after index start, searching
    // cyclically over the low n bits. Returns zero when no bit is set.
    function automatic logic [MAX_REQ-1:0] rr_first_from(
        input logic [MAX_REQ-1:0] vec,
        input logic [2:0]         start,
        input int                 n
    );
        logic [MAX_REQ-1:0] res;
        logic               found;
        logic [2:0]         idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = 3'((int'(start) + i) % n);
            if ((i < n) && !found && vec[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin selector with a registered priority pointer.
//               The pointer moves to one past the current owner on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_ctl_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NREQ-1:0] i_valid,
    input  logic [NREQ-1:0] i_owner,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_sel,
    output logic            o_any
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_owner_idx;
    logic [PW-1:0]      w_ptr_nxt;
    logic [MAX_REQ-1:0] w_vec;
    logic [MAX_REQ-1:0] w_pick;

    // Select the first valid requester at or after the pointer.
    always_comb begin
        w_vec           = '0;
        w_vec[NREQ-1:0] = i_valid;
        w_pick          = rr_first_from(w_vec, 3'(r_ptr), NREQ);
        o_sel           = w_pick[NREQ-1:0];
        o_any           = |w_pick;
    end

    // Next pointer is the owner index plus one, wrapping at NREQ.
    always_comb begin
        w_owner_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (i_owner[k]) begin
                w_owner_idx = PW'(k);
            end
        end
        w_ptr_nxt = (w_owner_idx == PW'(NREQ - 1)) ? '0 : (w_owner_idx + 1'b1);
    end

    // Priority pointer register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one byte-wide UART transmitter between NREQ requesters
//               with message-granular round-robin, start/busy sequencing,
//               an inter-byte idle gap and a mid-message lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_ctl_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*BYTE_W-1:0] i_req_data,
    input  logic [NREQ-1:0]        i_req_last,
    output logic [NREQ-1:0]        o_req_ready,
    output logic [NREQ-1:0]        o_grant,
    output logic                   o_tx_start,
    output logic [BYTE_W-1:0]      o_tx_data,
    input  logic                   i_tx_busy,
    output logic                   o_abort
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    state_t              r_state, w_state_nxt;
    logic [NREQ-1:0]     r_grant, w_grant_nxt;
    logic [BYTE_W-1:0]   r_data,  w_data_nxt;
    logic                r_last,  w_last_nxt;
    logic [TW-1:0]       r_tmo,   w_tmo_nxt;
    logic [GW-1:0]       r_gap,   w_gap_nxt;
    logic                w_adv;
    logic [NREQ-1:0]     w_sel;
    logic                w_any;
    logic                w_own_valid;
    logic                w_own_last;
    logic [BYTE_W-1:0]   w_own_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_req_valid),
        .i_owner   (r_grant),
        .i_advance (w_adv),
        .o_sel     (w_sel),
        .o_any     (w_any)
    );

    // Only the owner's request lines are observed while a grant is held.
    always_comb begin
        w_own_valid = |(i_req_valid & r_grant);
        w_own_last  = |(i_req_last  & r_grant);
        w_own_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                w_own_data = i_req_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state, datapath updates and pulse outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_tmo_nxt   = r_tmo;
        w_gap_nxt   = r_gap;
        w_adv       = 1'b0;
        o_req_ready = '0;
        o_tx_start  = 1'b0;
        o_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Waiting on busy here also covers a frame left running by reset.
                if (w_any && !i_tx_busy) begin
                    w_grant_nxt = w_sel;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_own_valid) begin
                    o_req_ready = r_grant;
                    w_data_nxt  = w_own_data;
                    w_last_nxt  = w_own_last;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_START;
                end else if (r_tmo == TW'(LOCK_TIMEOUT - 1)) begin
                    o_abort     = 1'b1;
                    w_grant_nxt = '0;
                    w_adv       = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            S_START: begin
                o_tx_start  = 1'b1;
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GW'(GAP_CYCLES)) begin
                    w_gap_nxt = '0;
                    if (r_last) begin
                        w_grant_nxt = '0;
                        w_adv       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_tmo   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_tmo   <= w_tmo_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    assign o_grant   = r_grant;
    assign o_tx_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter with a busy-for-N-cycles
//               transmitter model and table-driven requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 10;

    typedef struct packed {
        int         c;
        int         k;
        logic [7:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready, grant;
    logic        tx_start, abort;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;

    logic [3:0]  z_valid = '0;
    logic [31:0] z_data  = '0;
    logic [3:0]  z_last  = '0;
    logic [3:0]  z_ready, z_grant;
    logic        z_start, z_abort;
    logic [7:0]  z_txd;
    logic        z_busy = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int prot_err = 0;

    int         nb[4];
    logic [7:0] bt[4][8];
    logic       lt[4][8];
    int         stall[4];
    int         pos[4];
    int         rise_cyc[4];
    logic       clr_req = 1'b0;

    ev_t rdy_q[$];
    ev_t start_q[$];
    ev_t fall_q[$];
    int  abort_q[$];
    int  idle_q[$];
    int  own_q[$];
    logic [3:0] prev_grant = '0;
    int         busy_cnt = 0;
    logic [7:0] cur_byte = '0;
    logic       frame_ok = 1'b0;

    int z_busy_cnt = 0;
    int z_rdy_cnt  = 0;
    int z_start_q[$];
    int z_fall_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(16), .LOCK_TIMEOUT(8)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_busy(tx_busy), .o_abort(abort)
    );

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0), .LOCK_TIMEOUT(8)) dut_z (
        .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(z_valid), .i_req_data(z_data),
        .i_req_last(z_last), .o_req_ready(z_ready), .o_grant(z_grant),
        .o_tx_start(z_start), .o_tx_data(z_txd), .i_tx_busy(z_busy), .o_abort(z_abort)
    );

    function automatic int oh2i(input logic [3:0] v);
        int r;
        r = 99;
        if ($countones(v) == 1)
            for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester driver: present the current table byte just after each edge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (pos[k] < nb[k] && pos[k] != stall[k]) begin
                if (!req_valid[k]) rise_cyc[k] = cyc;
                req_valid[k]        = 1'b1;
                req_data[8*k +: 8]  = bt[k][pos[k]];
                req_last[k]         = lt[k][pos[k]];
            end else begin
                req_valid[k]        = 1'b0;
                req_data[8*k +: 8]  = 8'h00;
                req_last[k]         = 1'b0;
            end
        end
    end

    // Monitor and transmitter model for the main instance.
    always @(negedge clk) begin
        if (clr_req) for (int k = 0; k < 4; k++) pos[k] = 0;
        for (int k = 0; k < 4; k++) begin
            if (req_ready[k]) begin
                rdy_q.push_back('{c: cyc, k: k, d: req_data[8*k +: 8]});
                pos[k] = pos[k] + 1;
            end
        end
        if (($countones(req_ready) > 1) || ((req_ready & ~grant) != 4'b0)) prot_err++;
        if (grant != prev_grant) begin
            if (grant == 4'b0) idle_q.push_back(cyc);
            else own_q.push_back(oh2i(grant));
            prev_grant = grant;
        end
        if (abort) abort_q.push_back(cyc);
        if (!rst_n) frame_ok = 1'b0;
        if (tx_start) begin
            start_q.push_back('{c: cyc, k: 0, d: tx_data});
            cur_byte = tx_data;
            busy_cnt = BUSY_LEN;
            frame_ok = 1'b1;
        end else if (busy_cnt > 0) begin
            if (frame_ok && tx_data !== cur_byte) prot_err++;
            busy_cnt--;
            if (busy_cnt == 0) fall_q.push_back('{c: cyc, k: 0, d: tx_data});
        end
        tx_busy = (busy_cnt > 0);
    end

    // Monitor and transmitter model for the zero-gap instance.
    always @(negedge clk) begin
        if (z_ready != 4'b0) z_rdy_cnt++;
        if (z_start) begin
            z_start_q.push_back(cyc);
            z_busy_cnt = BUSY_LEN;
        end else if (z_busy_cnt > 0) begin
            z_busy_cnt--;
            if (z_busy_cnt == 0) z_fall_q.push_back(cyc);
        end
        z_busy = (z_busy_cnt > 0);
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic prep();
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            nb[k] = 0;
            stall[k] = -1;
        end
        rdy_q.delete(); start_q.delete(); fall_q.delete();
        abort_q.delete(); idle_q.delete(); own_q.delete();
    endtask

    task automatic go();
        clr_req = 1'b1;
        @(negedge clk); #1;
        clr_req = 1'b0;
    endtask

    task automatic wait_quiet(input int maxc);
        int q, n;
        q = 0;
        n = 0;
        while (q < 20 && n < maxc) begin
            @(negedge clk);
            n++;
            if (grant == 4'b0 && !tx_busy && req_valid == 4'b0) q++; else q = 0;
        end
        if (q < 20) chk("quiet_timeout", 1, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nb[k] = 0;
            stall[k] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_abort", abort, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Single one-byte message from requester 0.
        prep();
        nb[0] = 1; bt[0][0] = 8'hA5; lt[0][0] = 1'b1;
        go();
        wait_quiet(400);
        chk("t1_nready", rdy_q.size(), 1);
        chk("t1_ready_k", rdy_q[0].k, 0);
        chk("t1_ready_cyc", rdy_q[0].c, rise_cyc[0] + 1);
        chk("t1_start_cyc", start_q[0].c, rise_cyc[0] + 2);
        chk("t1_start_data", start_q[0].d, 8'hA5);
        chk("t1_fall_data", fall_q[0].d, 8'hA5);
        chk("t1_grant_owner", own_q[0], 0);
        chk("t1_idle_cyc", idle_q[0], fall_q[0].c + 18);

        // Requesters 0 and 2 together, three bytes each: no interleaving.
        do_reset();
        prep();
        nb[0] = 3; bt[0][0] = 8'h01; bt[0][1] = 8'h02; bt[0][2] = 8'h03;
        lt[0][0] = 1'b0; lt[0][1] = 1'b0; lt[0][2] = 1'b1;
        nb[2] = 3; bt[2][0] = 8'h21; bt[2][1] = 8'h22; bt[2][2] = 8'h23;
        lt[2][0] = 1'b0; lt[2][1] = 1'b0; lt[2][2] = 1'b1;
        go();
        wait_quiet(1000);
        chk("t2_nstart", start_q.size(), 6);
        begin
            logic [7:0] exp_d[6];
            int         exp_k[6];
            exp_d = '{8'h01, 8'h02, 8'h03, 8'h21, 8'h22, 8'h23};
            exp_k = '{0, 0, 0, 2, 2, 2};
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t2_k%0d", i), rdy_q[i].k, exp_k[i]);
                chk($sformatf("t2_d%0d", i), start_q[i].d, exp_d[i]);
                chk($sformatf("t2_hold%0d", i), fall_q[i].d, exp_d[i]);
            end
        end
        chk("t2_owners", own_q.size(), 2);
        // Pointer now sits at 3, so requester 3 beats requester 1.
        prep();
        nb[1] = 1; bt[1][0] = 8'h10; lt[1][0] = 1'b1;
        nb[3] = 1; bt[3][0] = 8'h30; lt[3][0] = 1'b1;
        go();
        wait_quiet(600);
        chk("t2_ptr_first", own_q[0], 3);
        chk("t2_ptr_second", own_q[1], 1);
        chk("t2_ptr_data", start_q[0].d, 8'h30);

        // All four continuously valid with one-byte messages: rotation.
        do_reset();
        prep();
        for (int k = 0; k < 4; k++) begin
            nb[k] = 2;
            bt[k][0] = 8'(8'h40 + k); lt[k][0] = 1'b1;
            bt[k][1] = 8'(8'h50 + k); lt[k][1] = 1'b1;
        end
        go();
        wait_quiet(1500);
        chk("t3_nown", own_q.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_own%0d", i), own_q[i], i % 4);

        // Gap of 16: busy-low edge to next start is 18 cycles.
        prep();
        nb[0] = 2; bt[0][0] = 8'h70; lt[0][0] = 1'b0; bt[0][1] = 8'h71; lt[0][1] = 1'b1;
        go();
        wait_quiet(600);
        chk("t4_gap16", start_q[1].c - fall_q[0].c - 1, 18);

        // Gap of 0 on the second instance: 2 cycles.
        @(posedge clk); #2;
        z_valid = 4'b0001; z_data = 32'h3C; z_last = 4'b0000;
        n = 0;
        while (z_rdy_cnt < 1 && n < 100) begin @(posedge clk); #2; n++; end
        z_data = 32'h3D; z_last = 4'b0001;
        while (z_rdy_cnt < 2 && n < 200) begin @(posedge clk); #2; n++; end
        if (n >= 200) chk("t4_z_ready_timeout", 1, 0);
        z_valid = 4'b0; z_last = 4'b0; z_data = 32'h0;
        repeat (30) @(posedge clk);
        chk("t4_z_nstart", z_start_q.size(), 2);
        chk("t4_gap0", z_start_q[1] - z_fall_q[0] - 1, 2);

        // Owner stalls after byte 1 of 3: lock timeout, then requester 1.
        do_reset();
        prep();
        nb[0] = 3; bt[0][0] = 8'h50; bt[0][1] = 8'h51; bt[0][2] = 8'h52;
        lt[0][0] = 1'b0; lt[0][1] = 1'b0; lt[0][2] = 1'b1; stall[0] = 1;
        nb[1] = 1; bt[1][0] = 8'h61; lt[1][0] = 1'b1;
        go();
        wait_quiet(800);
        chk("t5_nabort", abort_q.size(), 1);
        chk("t5_abort_cyc", abort_q[0], fall_q[0].c + 25);
        chk("t5_idle_cyc", idle_q[0], abort_q[0] + 1);
        chk("t5_next_owner", own_q[1], 1);
        chk("t5_next_ready", rdy_q[1].c, abort_q[0] + 2);
        chk("t5_next_data", start_q[1].d, 8'h61);

        // Reset while the core is busy with a frame.
        prep();
        nb[1] = 2; bt[1][0] = 8'h11; lt[1][0] = 1'b0; bt[1][1] = 8'h22; lt[1][1] = 1'b1;
        go();
        n = 0;
        while (start_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("t6_start_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_grant", grant, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_start", tx_start, 0);
        chk("t6_data", tx_data, 8'h00);
        chk("t6_abort", abort, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_quiet(600);
        chk("t6_nstart", start_q.size(), 2);
        chk("t6_restart_cyc", start_q[1].c, fall_q[0].c + 2);
        chk("t6_restart_data", start_q[1].d, 8'h22);

        chk("protocol", prot_err, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
